// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared widths, commit encoding and state types for the message outbox
package msg_pkg;
    localparam int SLOT_W = 5;
    localparam int WORD_W = 5;
    localparam logic [WORD_W-1:0] COMMIT_WORD = 5'd31;
    localparam logic [31:0]       COMMIT_VAL  = 32'h1;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        READY,
        DRAINING
    } slot_state_e;

    typedef enum logic {
        D_IDLE,
        D_SEND
    } drain_state_e;
endpackage

// File: rtl/slot_fifo.sv
// rtl/slot_fifo.sv - FIFO of committed slot indices, first-word fall-through
module slot_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/msg_outbox.sv
// rtl/msg_outbox.sv - slot-organised outbound message buffer with commit-order drain stream
module msg_outbox
    import msg_pkg::*;
#(
    parameter int NUM_SLOTS      = 32,
    parameter int WORDS_PER_SLOT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [9:0]        wr_addr,
    input  logic [31:0]       wr_data,
    output logic              wr_allowed,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [31:0]       tx_data,
    output logic [SLOT_W-1:0] tx_slot,
    output logic              tx_last,
    output logic              err_drop
);
    logic [31:0]       r_mem [NUM_SLOTS*WORDS_PER_SLOT];
    slot_state_e       r_state [NUM_SLOTS];
    logic [5:0]        r_len [NUM_SLOTS];
    logic [SLOT_W-1:0] r_fill_slot;
    logic              r_err_drop;
    drain_state_e      r_dstate;
    logic [SLOT_W-1:0] r_dslot;
    logic [5:0]        r_dlen;
    logic [5:0]        r_rd_idx;
    logic              r_tx_valid;
    logic              r_tx_last;
    logic [31:0]       r_tx_data;
    logic [SLOT_W-1:0] r_tx_slot;

    logic [SLOT_W-1:0] w_slot;
    logic [WORD_W-1:0] w_word;
    logic              w_acc;
    logic              w_slot_open;
    logic              w_is_data;
    logic              w_is_commit;
    logic              w_pop;
    logic              w_adv;
    logic              w_hs;
    logic              w_issue;
    logic [SLOT_W-1:0] w_fifo_dout;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    assign w_slot      = wr_addr[9:5];
    assign w_word      = wr_addr[4:0];
    assign wr_allowed  = !((r_state[r_fill_slot] == READY) || (r_state[r_fill_slot] == DRAINING));
    assign w_acc       = wr_valid && wr_allowed;
    assign w_slot_open = (r_state[w_slot] == FREE) || (r_state[w_slot] == FILLING);
    assign w_is_data   = w_slot_open && (w_word != COMMIT_WORD);
    assign w_is_commit = w_slot_open && (w_word == COMMIT_WORD) && (wr_data == COMMIT_VAL);
    assign w_pop       = (r_dstate == D_IDLE) && !w_fifo_empty;
    assign w_adv       = !r_tx_valid || tx_ready;
    assign w_hs        = r_tx_valid && tx_ready;
    assign w_issue     = (r_dstate == D_SEND) && w_adv && (r_rd_idx != r_dlen);

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign tx_slot  = r_tx_slot;
    assign tx_last  = r_tx_last;
    assign err_drop = r_err_drop;

    slot_fifo #(.DEPTH(NUM_SLOTS), .W(SLOT_W)) u_slot_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_acc && w_is_commit),
        .i_din   (w_slot),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge clk) begin
        if (w_acc && w_is_data) r_mem[wr_addr] <= wr_data;
    end

    // Slot bookkeeping: the write side only touches FREE/FILLING slots and the
    // drain side only READY/DRAINING ones, so both updates never hit the same slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= FREE;
                r_len[i]   <= '0;
            end
            r_fill_slot <= '0;
            r_err_drop  <= 1'b0;
            r_dstate    <= D_IDLE;
            r_dslot     <= '0;
            r_dlen      <= '0;
            r_rd_idx    <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_tx_data   <= '0;
            r_tx_slot   <= '0;
        end else begin
            if (w_acc) begin
                r_fill_slot <= w_slot;
                if (w_is_data) begin
                    r_state[w_slot] <= FILLING;
                    if ({1'b0, w_word} >= r_len[w_slot]) r_len[w_slot] <= {1'b0, w_word} + 6'd1;
                end else if (w_is_commit) begin
                    r_state[w_slot] <= READY;
                end else begin
                    r_err_drop <= 1'b1;
                end
            end

            case (r_dstate)
                D_IDLE: begin
                    if (w_pop) begin
                        r_dslot  <= w_fifo_dout;
                        r_dlen   <= r_len[w_fifo_dout];
                        r_rd_idx <= '0;
                        if (r_len[w_fifo_dout] == 6'd0) begin
                            r_state[w_fifo_dout] <= FREE;
                        end else begin
                            r_state[w_fifo_dout] <= DRAINING;
                            r_dstate             <= D_SEND;
                        end
                    end
                end
                D_SEND: begin
                    // The RAM read register doubles as the stream output register.
                    if (w_issue) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= r_mem[{r_dslot, r_rd_idx[4:0]}];
                        r_tx_slot  <= r_dslot;
                        r_tx_last  <= ((r_rd_idx + 6'd1) == r_dlen);
                        r_rd_idx   <= r_rd_idx + 6'd1;
                    end else if (w_hs) begin
                        r_tx_valid <= 1'b0;
                    end
                    if (w_hs && r_tx_last) begin
                        r_state[r_dslot] <= FREE;
                        r_len[r_dslot]   <= '0;
                        r_dstate         <= D_IDLE;
                    end
                end
                default: r_dstate <= D_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n) assert (!w_fifo_full);
    end
endmodule

// File: tb/tb_msg_outbox.sv
// tb/tb_msg_outbox.sv - directed self-checking bench for msg_outbox
module tb_msg_outbox;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        tx_ready = 1'b0;
    logic        wr_allowed;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [4:0]  tx_slot;
    logic        tx_last;
    logic        err_drop;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_data [$];
    logic [4:0]  q_slot [$];
    logic        q_last [$];

    msg_outbox dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_allowed (wr_allowed),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_slot    (tx_slot),
        .tx_last    (tx_last),
        .err_drop   (err_drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            q_data.push_back(tx_data);
            q_slot.push_back(tx_slot);
            q_last.push_back(tx_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_slot.delete();
        q_last.delete();
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_allowed && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (wr_allowed !== 1'b1) begin
            errors++;
            $display("FAIL wr_wait addr=%h: wr_allowed=%b required 1", a, wr_allowed);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        int c = 0;
        while (q_data.size() < n && c < 300) begin
            tick();
            c++;
        end
        checks++;
        if (q_data.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d beats, required %0d", name, q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (wr_allowed !== 1'b1) begin errors++; $display("FAIL reset_wr_allowed: got %b required 1", wr_allowed); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last: got %b required 0", tx_last); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop: got %b required 0", err_drop); end
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data: got %h required 0", tx_data); end
        checks++; if (tx_slot !== 5'd0) begin errors++; $display("FAIL reset_tx_slot: got %0d required 0", tx_slot); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_message();
        tx_ready = 1'b1;
        clear_q();
        wr(10'h040, 32'hA000_000A);
        wr(10'h041, 32'hB000_000B);
        wr(10'h042, 32'hC000_000C);
        wr(10'h05F, 32'h1);
        checks++; if (wr_allowed !== 1'b0) begin errors++; $display("FAIL single_stall_n1: wr_allowed=%b required 0", wr_allowed); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n1: tx_valid=%b required 0", tx_valid); end
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_n2: tx_valid=%b required 0", tx_valid); end
        tick();
        checks++; if ({tx_valid, tx_data, tx_slot, tx_last} !== {1'b1, 32'hA000_000A, 5'd2, 1'b0}) begin
            errors++; $display("FAIL single_beat0: v=%b d=%h s=%0d l=%b required 1 a000000a 2 0", tx_valid, tx_data, tx_slot, tx_last);
        end
        tick();
        checks++; if ({tx_valid, tx_data, tx_slot, tx_last} !== {1'b1, 32'hB000_000B, 5'd2, 1'b0}) begin
            errors++; $display("FAIL single_beat1: v=%b d=%h s=%0d l=%b required 1 b000000b 2 0", tx_valid, tx_data, tx_slot, tx_last);
        end
        tick();
        checks++; if ({tx_valid, tx_data, tx_slot, tx_last} !== {1'b1, 32'hC000_000C, 5'd2, 1'b1}) begin
            errors++; $display("FAIL single_beat2: v=%b d=%h s=%0d l=%b required 1 c000000c 2 1", tx_valid, tx_data, tx_slot, tx_last);
        end
        checks++; if (wr_allowed !== 1'b0) begin errors++; $display("FAIL single_stall_last: wr_allowed=%b required 0", wr_allowed); end
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: tx_valid=%b required 0", tx_valid); end
        checks++; if (wr_allowed !== 1'b1) begin errors++; $display("FAIL single_free: wr_allowed=%b required 1", wr_allowed); end
        checks++; if (q_data.size() != 3) begin errors++; $display("FAIL single_count: got %0d required 3", q_data.size()); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_d [3];
        int stall = 0;
        exp_d = '{32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
        tx_ready = 1'b1;
        clear_q();
        wr(10'h040, exp_d[0]);
        wr(10'h041, exp_d[1]);
        wr(10'h042, exp_d[2]);
        wr(10'h05F, 32'h1);
        for (int c = 0; c < 60 && q_data.size() < 3; c++) begin
            tx_ready = !(q_data.size() == 1 && stall < 5);
            if (!tx_ready) begin
                stall++;
                checks++;
                if ({tx_valid, tx_data, tx_last} !== {1'b1, exp_d[1], 1'b0}) begin
                    errors++; $display("FAIL bp_hold%0d: v=%b d=%h l=%b required 1 %h 0", stall, tx_valid, tx_data, tx_last, exp_d[1]);
                end
            end
            tick();
        end
        tx_ready = 1'b1;
        checks++; if (stall != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d required 5", stall); end
        checks++; if (q_data.size() != 3) begin errors++; $display("FAIL bp_count: got %0d required 3", q_data.size()); end
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            checks++;
            if ({q_data[i], q_slot[i], q_last[i]} !== {exp_d[i], 5'd2, (i == 2)}) begin
                errors++; $display("FAIL bp_beat%0d: d=%h s=%0d l=%b required %h 2 %b", i, q_data[i], q_slot[i], q_last[i], exp_d[i], (i == 2));
            end
        end
    endtask

    task automatic test_stall();
        bit held = 1'b1;
        tx_ready = 1'b0;
        wr(10'h060, 32'h3333_3333);
        wr(10'h07F, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (wr_allowed !== 1'b0) held = 1'b0;
            tick();
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL stall_held: wr_allowed rose while slot 3 pending, required 0"); end
        checks++; if ({tx_valid, tx_data, tx_slot, tx_last} !== {1'b1, 32'h3333_3333, 5'd3, 1'b1}) begin
            errors++; $display("FAIL stall_beat: v=%b d=%h s=%0d l=%b required 1 33333333 3 1", tx_valid, tx_data, tx_slot, tx_last);
        end
        tx_ready = 1'b1;
        checks++; if (wr_allowed !== 1'b0) begin errors++; $display("FAIL stall_before_hs: wr_allowed=%b required 0", wr_allowed); end
        tick();
        checks++; if (wr_allowed !== 1'b1) begin errors++; $display("FAIL stall_release: wr_allowed=%b required 1", wr_allowed); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_after: tx_valid=%b required 0", tx_valid); end
    endtask

    task automatic test_ordering();
        logic [31:0] exp_d [3];
        logic [4:0]  exp_s [3];
        logic        exp_l [3];
        exp_d = '{32'h50, 32'h51, 32'h10};
        exp_s = '{5'd5, 5'd5, 5'd1};
        exp_l = '{1'b0, 1'b1, 1'b1};
        tx_ready = 1'b1;
        clear_q();
        wr(10'h0A0, 32'h50);
        wr(10'h0A1, 32'h51);
        wr(10'h0BF, 32'h1);
        wr(10'h020, 32'h10);
        wr(10'h03F, 32'h1);
        wait_beats(3, "order");
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            checks++;
            if ({q_data[i], q_slot[i], q_last[i]} !== {exp_d[i], exp_s[i], exp_l[i]}) begin
                errors++; $display("FAIL order_beat%0d: d=%h s=%0d l=%b required %h %0d %b", i, q_data[i], q_slot[i], q_last[i], exp_d[i], exp_s[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_zero_length();
        bit quiet = 1'b1;
        tx_ready = 1'b1;
        clear_q();
        wr(10'h0FF, 32'h1);
        checks++; if (wr_allowed !== 1'b0) begin errors++; $display("FAIL zero_ready_n1: wr_allowed=%b required 0", wr_allowed); end
        tick();
        checks++; if (wr_allowed !== 1'b1) begin errors++; $display("FAIL zero_free_n2: wr_allowed=%b required 1", wr_allowed); end
        for (int i = 0; i < 6; i++) begin
            if (tx_valid !== 1'b0) quiet = 1'b0;
            tick();
        end
        checks++; if (quiet !== 1'b1 || q_data.size() != 0) begin
            errors++; $display("FAIL zero_no_beats: beats=%0d quiet=%b required 0 beats", q_data.size(), quiet);
        end
    endtask

    task automatic test_len_max();
        tx_ready = 1'b1;
        clear_q();
        wr(10'h121, 32'h91);
        wr(10'h120, 32'h90);
        wr(10'h13F, 32'h1);
        wait_beats(2, "lenmax");
        if (q_data.size() == 2) begin
            checks++;
            if ({q_data[0], q_last[0], q_data[1], q_last[1]} !== {32'h90, 1'b0, 32'h91, 1'b1}) begin
                errors++; $display("FAIL lenmax_beats: %h/%b %h/%b required 00000090/0 00000091/1", q_data[0], q_last[0], q_data[1], q_last[1]);
            end
        end
        clear_q();
        wr(10'h15E, 32'hAE);
        wr(10'h15F, 32'h1);
        wait_beats(31, "word30");
        if (q_data.size() == 31) begin
            checks++;
            if ({q_data[30], q_slot[30], q_last[30], q_last[29]} !== {32'hAE, 5'd10, 1'b1, 1'b0}) begin
                errors++; $display("FAIL word30_tail: d=%h s=%0d l=%b prev_l=%b required ae 10 1 0", q_data[30], q_slot[30], q_last[30], q_last[29]);
            end
        end
    endtask

    task automatic test_bad_commit();
        logic [31:0] exp_d [3];
        bit blocked = 1'b1;
        exp_d = '{32'h60, 32'h61, 32'h62};
        tick();
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL bad_pre: err_drop=%b required 0", err_drop); end
        wr(10'h0FF, 32'h2);
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL bad_commit_drop: err_drop=%b required 1", err_drop); end
        checks++; if (wr_allowed !== 1'b1) begin errors++; $display("FAIL bad_commit_allowed: wr_allowed=%b required 1", wr_allowed); end
        tx_ready = 1'b0;
        clear_q();
        wr(10'h0C0, exp_d[0]);
        wr(10'h0C1, exp_d[1]);
        wr(10'h0C2, exp_d[2]);
        wr(10'h0DF, 32'h1);
        for (int i = 0; i < 4; i++) tick();
        wr_valid = 1'b1;
        wr_addr  = 10'h0C0;
        wr_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (wr_allowed !== 1'b0) blocked = 1'b0;
            tick();
        end
        wr_valid = 1'b0;
        checks++; if (blocked !== 1'b1) begin errors++; $display("FAIL bad_draining_blocked: write to draining slot 6 was allowed, required blocked"); end
        tx_ready = 1'b1;
        wait_beats(3, "bad_stream");
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            checks++;
            if ({q_data[i], q_slot[i], q_last[i]} !== {exp_d[i], 5'd6, (i == 2)}) begin
                errors++; $display("FAIL bad_beat%0d: d=%h s=%0d l=%b required %h 6 %b", i, q_data[i], q_slot[i], q_last[i], exp_d[i], (i == 2));
            end
        end
        checks++; if (err_drop !== 1'b1) begin errors++; $display("FAIL bad_sticky: err_drop=%b required 1", err_drop); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b0;
        wr(10'h100, 32'h80);
        wr(10'h11F, 32'h1);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending: tx_valid=%b required 1", tx_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({tx_valid, tx_last, err_drop, wr_allowed} !== 4'b0001) begin
            errors++; $display("FAIL rmid_outputs: v=%b l=%b err=%b allowed=%b required 0 0 0 1", tx_valid, tx_last, err_drop, wr_allowed);
        end
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 8; i++) tick();
        checks++; if (q_data.size() != 0) begin errors++; $display("FAIL rmid_flushed: got %0d beats required 0", q_data.size()); end
        wr(10'h100, 32'h81);
        wr(10'h11F, 32'h1);
        wait_beats(1, "rmid_after");
        if (q_data.size() == 1) begin
            checks++;
            if ({q_data[0], q_slot[0], q_last[0]} !== {32'h81, 5'd8, 1'b1}) begin
                errors++; $display("FAIL rmid_beat: d=%h s=%0d l=%b required 81 8 1", q_data[0], q_slot[0], q_last[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_message();
        test_back_pressure();
        test_stall();
        test_ordering();
        test_zero_length();
        test_len_max();
        test_bad_commit();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
